// File: rtl/reg_bank_sequencer.sv
// Command-driven bus master for the 8088 register bank. Turns one-shot
// READ / WRITE / MOV / XCHG commands into RD/WR bus cycles on a shared
// tri-state DATA bus and returns exactly one response per command.
// All bus outputs are registered from the next state, so RD/WR/SEL/DATA
// change only on the clock edge that enters a phase.
module reg_bank_sequencer #(
    parameter int TURN_CYC = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [3:0]  cmd_src_i,
    input  logic [3:0]  cmd_dst_i,
    input  logic [15:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        rd_o,
    output logic        wr_o,
    output logic [3:0]  sel_o,
    inout  wire  [15:0] data_io
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_XCHG  = 2'b11;
    // The turnaround counter is loaded with TURN_CYC-1 and exits at zero.
    localparam logic [1:0] TURN_LOAD = (TURN_CYC > 0) ? 2'(TURN_CYC - 1) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_TURN, S_WR_A, S_WR_B, S_RSP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  turn_q, turn_d;
    logic [1:0]  op_q;
    logic [3:0]  src_q, dst_q;
    logic [15:0] wdat_q;
    logic [15:0] tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] dout_q, dout_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] rsp_data_q, rsp_data_d;

    logic        accept;
    logic        width_err;
    logic [1:0]  cur_op;
    logic [3:0]  cur_src, cur_dst;
    logic [15:0] cur_wdat;
    logic [15:0] rd_val;

    assign accept    = (state_q == S_IDLE) && cmd_valid_i;
    // MOV/XCHG between an 8-bit and a 16-bit register is refused outright.
    assign width_err = cmd_op_i[1] && (cmd_src_i[3] != cmd_dst_i[3]);
    // On the accepting edge the command fields are not latched yet, so the
    // first phase is set up straight from the inputs.
    assign cur_op    = accept ? cmd_op_i   : op_q;
    assign cur_src   = accept ? cmd_src_i  : src_q;
    assign cur_dst   = accept ? cmd_dst_i  : dst_q;
    assign cur_wdat  = accept ? cmd_data_i : wdat_q;
    // 8-bit reads are zero-extended whatever the bank puts on the upper byte.
    assign rd_val    = sel_q[3] ? data_io : {8'h00, data_io[7:0]};

    // State register plus the command/capture datapath.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            turn_q  <= 2'd0;
            op_q    <= 2'd0;
            src_q   <= 4'd0;
            dst_q   <= 4'd0;
            wdat_q  <= 16'h0;
            tmp_a_q <= 16'h0;
            tmp_b_q <= 16'h0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            tmp_a_q <= tmp_a_d;
            tmp_b_q <= tmp_b_d;
            if (accept) begin
                op_q   <= cmd_op_i;
                src_q  <= cmd_src_i;
                dst_q  <= cmd_dst_i;
                wdat_q <= cmd_data_i;
            end
        end
    end

    // Next-state logic: phase sequencing and turnaround down-count.
    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (width_err)                  state_d = S_RSP;
                    else if (cmd_op_i == OP_WRITE)  state_d = S_WR_A;
                    else                            state_d = S_RD_A;
                end
            end
            S_RD_A, S_RD_B: begin
                if (state_q == S_RD_A && op_q == OP_READ) begin
                    state_d = S_RSP;
                end else if (state_q == S_RD_A && op_q == OP_XCHG) begin
                    state_d = S_RD_B;
                end else if (TURN_CYC == 0) begin
                    state_d = S_WR_A;
                end else begin
                    state_d = S_TURN;
                    turn_d  = TURN_LOAD;
                end
            end
            S_TURN: begin
                if (turn_q == 2'd0) state_d = S_WR_A;
                else                turn_d  = turn_q - 2'd1;
            end
            S_WR_A:  state_d = (op_q == OP_XCHG) ? S_WR_B : S_RSP;
            S_WR_B:  state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: bus and response values for the phase being entered.
    always_comb begin
        tmp_a_d     = (state_q == S_RD_A) ? rd_val : tmp_a_q;
        tmp_b_d     = (state_q == S_RD_B) ? rd_val : tmp_b_q;
        rd_d        = (state_d == S_RD_A) || (state_d == S_RD_B);
        wr_d        = (state_d == S_WR_A) || (state_d == S_WR_B);
        sel_d       = sel_q;
        dout_d      = 16'h0;
        case (state_d)
            S_RD_A: sel_d = cur_src;
            S_RD_B: sel_d = cur_dst;
            S_WR_A: begin
                sel_d  = cur_dst;
                dout_d = (cur_op == OP_WRITE) ? cur_wdat : tmp_a_d;
            end
            S_WR_B: begin
                sel_d  = cur_src;
                dout_d = tmp_b_d;
            end
            default: ;
        endcase
        if (!sel_d[3]) dout_d[15:8] = 8'h00;
        rsp_valid_d = (state_d == S_RSP);
        // Only a refused command goes from IDLE straight to RSP.
        rsp_err_d   = (state_q == S_IDLE) && (state_d == S_RSP);
        rsp_data_d  = rsp_data_q;
        if (rsp_valid_d && !rsp_err_d)
            rsp_data_d = (op_q == OP_WRITE) ? wdat_q : tmp_a_d;
    end

    // Output register: keeps every bus and response output glitch-free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            sel_q       <= 4'd0;
            dout_q      <= 16'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 16'h0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            sel_q       <= sel_d;
            dout_q      <= dout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign data_io     = wr_q ? dout_q : 16'hzzzz;
    assign cmd_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_data_o  = rsp_data_q;
    assign rd_o        = rd_q;
    assign wr_o        = wr_q;
    assign sel_o       = sel_q;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Bench for reg_bank_sequencer: a behavioural 8088 register bank on the
// shared bus, a reference register model that predicts every response,
// and a queue of expected responses checked when RSP_VALID pulses.
module tb_reg_bank_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_src, cmd_dst;
    logic [15:0] cmd_data;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic        rd, wr;
    logic [3:0]  sel;
    wire  [15:0] data;

    // Second instance with no turnaround; its bank always reads 16'h5A5A.
    logic        v1, rdy1, rv1, re1, rd1, wr1;
    logic [1:0]  op1;
    logic [3:0]  src1, dst1, sel1;
    logic [15:0] cd1, rdat1;
    wire  [15:0] data1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        err;
        logic [15:0] data;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;
    exp_t sb[$];

    logic [15:0] bank [8];   // the "real" bank on the bus
    logic [15:0] mreg [8];   // bench reference model
    logic [15:0] m_last;     // model of held RSP_DATA

    always #5 clk = ~clk;

    reg_bank_sequencer #(.TURN_CYC(1)) dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .rd_o(rd), .wr_o(wr), .sel_o(sel), .data_io(data)
    );

    reg_bank_sequencer #(.TURN_CYC(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(v1), .cmd_ready_o(rdy1),
        .cmd_op_i(op1), .cmd_src_i(src1), .cmd_dst_i(dst1), .cmd_data_i(cd1),
        .rsp_valid_o(rv1), .rsp_data_o(rdat1), .rsp_err_o(re1),
        .rd_o(rd1), .wr_o(wr1), .sel_o(sel1), .data_io(data1)
    );

    // Bank read: 8-bit registers put junk on the upper byte on purpose.
    function automatic logic [15:0] bank_rd(input logic [3:0] s);
        logic [15:0] w;
        w = bank[{1'b0, s[1:0]}];
        if (s[3])      return bank[s[2:0]];
        else if (s[2]) return {8'hA5, w[15:8]};
        else           return {8'hA5, w[7:0]};
    endfunction

    assign data  = rd  ? bank_rd(sel) : 16'hzzzz;
    assign data1 = rd1 ? 16'h5A5A     : 16'hzzzz;

    always @(posedge clk) begin
        if (wr) begin
            if (sel[3])      bank[sel[2:0]]             <= data;
            else if (sel[2]) bank[{1'b0, sel[1:0]}][15:8] <= data[7:0];
            else             bank[{1'b0, sel[1:0]}][7:0]  <= data[7:0];
        end
    end

    function automatic logic [15:0] m_rd(input logic [3:0] s);
        logic [15:0] w;
        w = mreg[{1'b0, s[1:0]}];
        if (s[3])      return mreg[s[2:0]];
        else if (s[2]) return {8'h00, w[15:8]};
        else           return {8'h00, w[7:0]};
    endfunction

    task automatic m_wr(input logic [3:0] s, input logic [15:0] v);
        if (s[3])      mreg[s[2:0]]               = v;
        else if (s[2]) mreg[{1'b0, s[1:0]}][15:8] = v[7:0];
        else           mreg[{1'b0, s[1:0]}][7:0]  = v[7:0];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full command: predict, drive, wait for the response, compare.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] s, input logic [3:0] d,
                           input logic [15:0] cd);
        exp_t e, g;
        logic [15:0] a, b;
        int cyc, nrd, nwr;
        bit got, overlap, hi_dirty, ready_busy;
        e.err = op[1] && (s[3] != d[3]);
        if (e.err) begin
            e.data = m_last; e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else begin
            case (op)
                2'b00: begin e.data = m_rd(s); e.lat = 2; e.nrd = 1; e.nwr = 0; end
                2'b01: begin e.data = cd; m_wr(d, cd); e.lat = 2; e.nrd = 0; e.nwr = 1; end
                2'b10: begin
                    a = m_rd(s); m_wr(d, a);
                    e.data = a; e.lat = 4; e.nrd = 1; e.nwr = 1;
                end
                default: begin
                    a = m_rd(s); b = m_rd(d); m_wr(d, a); m_wr(s, b);
                    e.data = a; e.lat = 6; e.nrd = 2; e.nwr = 2;
                end
            endcase
            m_last = e.data;
        end
        sb.push_back(e);

        @(negedge clk);
        check("ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = s; cmd_dst = d; cmd_data = cd;
        @(posedge clk);
        @(negedge clk);
        if (!e.err) begin
            if (op == 2'b01)
                check("cyc1_wr_sel_data", {15'd0, wr, rd, sel, data}, {15'd0, 1'b1, 1'b0, d, d[3] ? cd : {8'h00, cd[7:0]}});
            else
                check("cyc1_rd_sel", {26'd0, rd, wr, sel}, {26'd0, 1'b1, 1'b0, s});
        end
        cyc = 1; nrd = 0; nwr = 0; got = 0; overlap = 0; hi_dirty = 0; ready_busy = 0;
        while (cyc <= 20) begin
            if (rd && wr) overlap = 1;
            if (rd) nrd++;
            if (wr) begin
                nwr++;
                if (!sel[3] && data[15:8] != 8'h00) hi_dirty = 1;
            end
            if (rsp_valid) begin got = 1; break; end
            if (cmd_ready) ready_busy = 1;
            // Garbage on the command port while busy must be ignored.
            cmd_op = ~op; cmd_src = ~s; cmd_dst = ~d; cmd_data = 16'($urandom);
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        g = sb.pop_front();
        check("rsp_seen", {31'd0, got}, 32'd1);
        if (got) begin
            check("rsp_err", {31'd0, rsp_err}, {31'd0, g.err});
            check("rsp_data", {16'd0, rsp_data}, {16'd0, g.data});
            check("latency", cyc, g.lat);
        end
        check("rd_cycles", nrd, g.nrd);
        check("wr_cycles", nwr, g.nwr);
        check("no_rd_wr_overlap", {31'd0, overlap}, 32'd0);
        check("byte_wr_upper_zero", {31'd0, hi_dirty}, 32'd0);
        check("ready_low_busy", {31'd0, ready_busy}, 32'd0);
        $display("txn op=%0d src=%0d dst=%0d data=%h -> rsp=%h err=%b lat=%0d", op, s, d, cd,
                 rsp_data, rsp_err, cyc);
        @(negedge clk);
        check("rsp_one_cycle_idle", {29'd0, rsp_valid, cmd_ready, rd | wr}, {29'd0, 1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        int cyc;
        bit seen_wr, spurious, wr_ok;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_src = 4'd0; cmd_dst = 4'd0; cmd_data = 16'h0;
        v1 = 1'b0; op1 = 2'd0; src1 = 4'd0; dst1 = 4'd0; cd1 = 16'h0;
        m_last = 16'h0;
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {8'd0, cmd_ready, rsp_valid, rsp_err, rd, wr, sel, rsp_data},
              {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0});
        rst = 1'b0;

        run_cmd(2'b01, 4'd0, 4'd8,  16'h1234);   // WRITE AX
        run_cmd(2'b00, 4'd0, 4'd0,  16'h0);      // READ AL -> 0034
        run_cmd(2'b00, 4'd4, 4'd0,  16'h0);      // READ AH -> 0012
        run_cmd(2'b01, 4'd0, 4'd12, 16'hBEEF);   // WRITE SP
        run_cmd(2'b10, 4'd12, 4'd13, 16'h0);     // MOV BP <= SP
        run_cmd(2'b00, 4'd13, 4'd0, 16'h0);      // READ BP
        run_cmd(2'b01, 4'd0, 4'd14, 16'h1111);   // WRITE SI
        run_cmd(2'b01, 4'd0, 4'd15, 16'h2222);   // WRITE DI
        run_cmd(2'b11, 4'd14, 4'd15, 16'h0);     // XCHG SI,DI
        run_cmd(2'b00, 4'd14, 4'd0, 16'h0);
        run_cmd(2'b00, 4'd15, 4'd0, 16'h0);
        run_cmd(2'b01, 4'd0, 4'd1,  16'hABCD);   // WRITE CL (low byte only)
        run_cmd(2'b10, 4'd1, 4'd8,  16'h0);      // MOV AX <= CL : width error
        run_cmd(2'b00, 4'd8, 4'd0,  16'h0);      // AX unchanged
        run_cmd(2'b10, 4'd1, 4'd2,  16'h0);      // MOV DL <= CL
        run_cmd(2'b00, 4'd2, 4'd0,  16'h0);
        run_cmd(2'b01, 4'd0, 4'd9,  16'h5555);   // WRITE CX
        run_cmd(2'b11, 4'd9, 4'd9,  16'h0);      // XCHG CX,CX
        run_cmd(2'b00, 4'd9, 4'd0,  16'h0);
        run_cmd(2'b11, 4'd0, 4'd4,  16'h0);      // XCHG AL,AH
        run_cmd(2'b00, 4'd8, 4'd0,  16'h0);      // AX -> 3412

        // Reset during the first write phase of an XCHG SI,DI.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_src = 4'd14; cmd_dst = 4'd15;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        seen_wr = 0; spurious = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (rsp_valid) spurious = 1;
            if (wr) begin seen_wr = 1; break; end
            @(negedge clk);
        end
        check("xchg_reached_wr_a", {31'd0, seen_wr}, 32'd1);
        rst = 1'b1;
        m_wr(4'd15, m_rd(4'd14));   // the WR_A write completes on the reset edge
        m_last = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_idle", {29'd0, cmd_ready, wr, rsp_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || wr || rd) spurious = 1;
            @(negedge clk);
        end
        check("abort_no_activity", {31'd0, spurious}, 32'd0);
        run_cmd(2'b00, 4'd15, 4'd0, 16'h0);      // DI got SI
        run_cmd(2'b00, 4'd14, 4'd0, 16'h0);      // SI untouched

        // TURN_CYC=0 instance: MOV CX <= DX responds in cycle 3.
        @(negedge clk);
        v1 = 1'b1; op1 = 2'b10; src1 = 4'd10; dst1 = 4'd9; cd1 = 16'h0;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        check("t0_cyc1_rd", {27'd0, rd1, sel1}, {27'd0, 1'b1, 4'd10});
        wr_ok = 0; seen_wr = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (rv1) break;
            if (wr1) begin
                seen_wr = 1;
                wr_ok = (cyc == 2) && (sel1 == 4'd9) && (data1 == 16'h5A5A);
            end
            @(negedge clk);
        end
        check("t0_wr_phase", {30'd0, seen_wr, wr_ok}, {30'd0, 1'b1, 1'b1});
        check("t0_latency", cyc, 3);
        check("t0_rsp", {15'd0, re1, rdat1}, {15'd0, 1'b0, 16'h5A5A});
        $display("txn dut0 MOV src=10 dst=9 -> rsp=%h err=%b lat=%0d", rdat1, re1, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
